// File: rtl/decode_ctrl_stage.sv
// Decode/control stage: turns a 32-bit RV32I instruction into a registered control bundle,
// with a valid/ready handshake, flush, and an optional load-use bubble.
module decode_ctrl_stage #(
  parameter int ALUOP_W      = 8,
  parameter int CNT_W        = 16,
  parameter int LU_INTERLOCK = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inst_valid_i,
  input  logic [31:0]        inst_i,
  output logic               inst_ready_o,
  input  logic               ex_ready_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic               memread_o,
  output logic               memwrite_o,
  output logic               memtoreg_o,
  output logic               alusrc_o,
  output logic               regwrite_o,
  output logic               reg_read1_e_o,
  output logic               reg_read2_e_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [4:0]         rd_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_OR   = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd10;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  typedef struct packed {
    logic branch;
    logic jump;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
    logic regwrite;
    logic re1;
    logic re2;
  } ctrl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [6:0]       w_opcode;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  ctrl_t            w_raw;
  logic [3:0]       w_raw_alu;
  logic             w_illegal;
  ctrl_t            w_dec;
  logic [3:0]       w_dec_alu;
  logic [4:0]       w_dec_rs1;
  logic [4:0]       w_dec_rs2;
  logic [4:0]       w_dec_rd;
  logic             w_hazard;
  logic             w_capture;
  state_t           w_state_nxt;

  state_t           r_state;
  logic             r_out_valid;
  ctrl_t            r_ctrl;
  logic [ALUOP_W-1:0] r_aluop;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic             r_illegal;
  logic [CNT_W-1:0] r_bubble_cnt;

  assign w_opcode = inst_i[6:0];
  assign w_rd     = inst_i[11:7];
  assign w_f3     = inst_i[14:12];
  assign w_rs1    = inst_i[19:15];
  assign w_rs2    = inst_i[24:20];
  assign w_f7     = inst_i[31:25];

  // Raw opcode/funct decode; legality is judged here, masking happens below.
  always_comb begin
    w_raw     = '0;
    w_raw_alu = ALU_NOP;
    w_illegal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_raw.regwrite = 1'b1;
        w_raw.re1      = 1'b1;
        w_raw.re2      = 1'b1;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'b000:  w_raw_alu = ALU_ADD;
            3'b001:  w_raw_alu = ALU_SLL;
            3'b010:  w_raw_alu = ALU_SLT;
            3'b011:  w_raw_alu = ALU_SLTU;
            3'b100:  w_raw_alu = ALU_XOR;
            3'b101:  w_raw_alu = ALU_SRL;
            3'b110:  w_raw_alu = ALU_OR;
            3'b111:  w_raw_alu = ALU_AND;
            default: w_illegal = 1'b1;
          endcase
        end else if (w_f7 == F7_ALT) begin
          case (w_f3)
            3'b000:  w_raw_alu = ALU_SUB;
            3'b101:  w_raw_alu = ALU_SRA;
            default: w_illegal = 1'b1;
          endcase
        end else begin
          w_illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        w_raw.alusrc   = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw.re1      = 1'b1;
        case (w_f3)
          3'b000: w_raw_alu = ALU_ADD;
          3'b010: w_raw_alu = ALU_SLT;
          3'b011: w_raw_alu = ALU_SLTU;
          3'b100: w_raw_alu = ALU_XOR;
          3'b110: w_raw_alu = ALU_OR;
          3'b111: w_raw_alu = ALU_AND;
          3'b001: begin
            if (w_f7 == F7_BASE) begin
              w_raw_alu = ALU_SLL;
            end else begin
              w_illegal = 1'b1;
            end
          end
          3'b101: begin
            if (w_f7 == F7_BASE) begin
              w_raw_alu = ALU_SRL;
            end else if (w_f7 == F7_ALT) begin
              w_raw_alu = ALU_SRA;
            end else begin
              w_illegal = 1'b1;
            end
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_raw.memread  = 1'b1;
        w_raw.memtoreg = 1'b1;
        w_raw.alusrc   = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw.re1      = 1'b1;
        w_raw_alu      = ALU_ADD;
        w_illegal      = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_raw.memwrite = 1'b1;
        w_raw.alusrc   = 1'b1;
        w_raw.re1      = 1'b1;
        w_raw.re2      = 1'b1;
        w_raw_alu      = ALU_ADD;
        w_illegal      = w_f3[2] || (w_f3[1:0] == 2'b11);
      end
      OPC_BRANCH: begin
        w_raw.branch = 1'b1;
        w_raw.re1    = 1'b1;
        w_raw.re2    = 1'b1;
        w_raw_alu    = ALU_SUB;
        w_illegal    = (w_f3[2:1] == 2'b01);
      end
      OPC_LUI, OPC_AUIPC: begin
        w_raw.alusrc   = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw_alu      = ALU_ADD;
      end
      OPC_JAL: begin
        w_raw.jump     = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw_alu      = ALU_ADD;
      end
      OPC_JALR: begin
        w_raw.jump     = 1'b1;
        w_raw.regwrite = 1'b1;
        w_raw.alusrc   = 1'b1;
        w_raw.re1      = 1'b1;
        w_raw_alu      = ALU_ADD;
        w_illegal      = (w_f3 != 3'b000);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Illegal instructions carry no side effects; x0 never gets written; disabled ports read 0.
  always_comb begin
    w_dec     = w_raw;
    w_dec_alu = w_raw_alu;
    w_dec_rd  = w_rd;
    if (w_illegal) begin
      w_dec     = '0;
      w_dec_alu = ALU_NOP;
      w_dec_rd  = 5'd0;
    end else if (w_rd == 5'd0) begin
      w_dec.regwrite = 1'b0;
    end else begin
      w_dec.regwrite = w_raw.regwrite;
    end
    w_dec_rs1 = w_dec.re1 ? w_rs1 : 5'd0;
    w_dec_rs2 = w_dec.re2 ? w_rs2 : 5'd0;
  end

  assign w_hazard = (LU_INTERLOCK != 0) && r_out_valid && r_ctrl.memread &&
                    (r_rd != 5'd0) && ex_ready_i && inst_valid_i &&
                    ((w_dec.re1 && (w_dec_rs1 == r_rd)) ||
                     (w_dec.re2 && (w_dec_rs2 == r_rd)));

  assign inst_ready_o = rst_i && !flush_i && (r_state == ST_RUN) && !w_hazard &&
                        (!r_out_valid || ex_ready_i);
  assign w_capture    = inst_valid_i && inst_ready_o;

  // Next-state logic: a load-use hazard costs exactly one BUBBLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard) begin
            w_state_nxt = ST_BUBBLE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_BUBBLE: w_state_nxt = ST_RUN;
        default:   w_state_nxt = ST_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output bundle: reset > flush > capture > bubble > drain > hold.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_out_valid  <= 1'b0;
      r_ctrl       <= '0;
      r_aluop      <= ALUOP_W'(ALU_NOP);
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
      r_illegal    <= 1'b0;
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_ctrl      <= w_dec;
      r_aluop     <= ALUOP_W'(w_dec_alu);
      r_rs1       <= w_dec_rs1;
      r_rs2       <= w_dec_rs2;
      r_rd        <= w_dec_rd;
      r_illegal   <= w_illegal;
    end else if (w_hazard) begin
      r_out_valid  <= 1'b0;
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end else if (ex_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o   = r_out_valid;
  assign branch_o      = r_ctrl.branch;
  assign jump_o        = r_ctrl.jump;
  assign memread_o     = r_ctrl.memread;
  assign memwrite_o    = r_ctrl.memwrite;
  assign memtoreg_o    = r_ctrl.memtoreg;
  assign alusrc_o      = r_ctrl.alusrc;
  assign regwrite_o    = r_ctrl.regwrite;
  assign reg_read1_e_o = r_ctrl.re1;
  assign reg_read2_e_o = r_ctrl.re2;
  assign aluop_o       = r_aluop;
  assign rs1_o         = r_rs1;
  assign rs2_o         = r_rs2;
  assign rd_o          = r_rd;
  assign illegal_o     = r_illegal;
  assign bubble_cnt_o  = r_bubble_cnt;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: three instances share stimulus
// (default, interlock disabled, 4-bit bubble counter) and are checked against hand-computed values.
module tb_decode_ctrl_stage;

  localparam logic [7:0] A_NOP = 8'd0;
  localparam logic [7:0] A_ADD = 8'd1;
  localparam logic [7:0] A_SUB = 8'd2;
  localparam logic [7:0] A_SRA = 8'd8;
  localparam logic [7:0] A_OR  = 8'd9;

  // flag order: branch jump memread memwrite memtoreg alusrc regwrite re1 re2
  localparam logic [8:0] F_R    = 9'b000000111;
  localparam logic [8:0] F_LW   = 9'b001011110;
  localparam logic [8:0] F_LUI  = 9'b000001100;

  localparam logic [31:0] I_ADD3 = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_LW5  = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00528333;  // add x6,x5,x5
  localparam logic [31:0] I_LUI4 = 32'h12345237;  // lui x4,0x12345

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid;
  logic [31:0] inst;
  logic        ex_ready;
  logic        flush;

  logic        ready [3];
  logic        oval  [3];
  logic        ill   [3];
  logic [8:0]  flags [3];
  logic [7:0]  aluop [3];
  logic [14:0] regs  [3];
  logic [15:0] cnt   [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 4 : 16;
    localparam int LU = (g == 1) ? 0 : 1;
    logic br, jp, mr, mw, mt, as, rw, r1, r2, rdy, ov, il;
    logic [7:0]    alu;
    logic [4:0]    a1, a2, ad;
    logic [CW-1:0] bc;

    decode_ctrl_stage #(.ALUOP_W(8), .CNT_W(CW), .LU_INTERLOCK(LU)) u_dut (
      .clk_i(clk), .rst_i(rst_n), .inst_valid_i(inst_valid), .inst_i(inst),
      .inst_ready_o(rdy), .ex_ready_i(ex_ready), .flush_i(flush), .out_valid_o(ov),
      .branch_o(br), .jump_o(jp), .memread_o(mr), .memwrite_o(mw), .memtoreg_o(mt),
      .alusrc_o(as), .regwrite_o(rw), .reg_read1_e_o(r1), .reg_read2_e_o(r2),
      .aluop_o(alu), .rs1_o(a1), .rs2_o(a2), .rd_o(ad), .illegal_o(il),
      .bubble_cnt_o(bc)
    );

    assign ready[g] = rdy;
    assign oval[g]  = ov;
    assign ill[g]   = il;
    assign flags[g] = {br, jp, mr, mw, mt, as, rw, r1, r2};
    assign aluop[g] = alu;
    assign regs[g]  = {a1, a2, ad};
    assign cnt[g]   = 16'(bc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [8:0]  fl;
    logic [7:0]  alu;
    logic        il;
    logic [14:0] rr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{32'h002081B3, F_R,          A_ADD, 1'b0, {5'd1, 5'd2, 5'd3}};
    vecs[1] = '{32'h402084B3, F_R,          A_SUB, 1'b0, {5'd1, 5'd2, 5'd9}};
    vecs[2] = '{32'h00208033, 9'b000000011, A_ADD, 1'b0, {5'd1, 5'd2, 5'd0}};
    vecs[3] = '{32'h4030D413, 9'b000001110, A_SRA, 1'b0, {5'd1, 5'd0, 5'd8}};
    vecs[4] = '{32'h0230D413, 9'b000000000, A_NOP, 1'b1, {5'd0, 5'd0, 5'd0}};
    vecs[5] = '{32'h0020A223, 9'b000101011, A_ADD, 1'b0, {5'd1, 5'd2, 5'd4}};
    vecs[6] = '{32'h00208463, 9'b100000011, A_SUB, 1'b0, {5'd1, 5'd2, 5'd8}};
    vecs[7] = '{32'h000000EF, 9'b010000100, A_ADD, 1'b0, {5'd0, 5'd0, 5'd1}};
    vecs[8] = '{32'h0000007F, 9'b000000000, A_NOP, 1'b1, {5'd0, 5'd0, 5'd0}};
    vecs[9] = '{32'h0020E533, F_R,          A_OR,  1'b0, {5'd1, 5'd2, 5'd10}};

    rst_n = 1'b0; inst_valid = 1'b0; inst = 32'd0; ex_ready = 1'b1; flush = 1'b0;
    #2 check_eq("rst_ready", 32'(ready[0]), 32'd0);
    tick; tick;
    check_eq("rst_oval",  32'(oval[0]),  32'd0);
    check_eq("rst_flags", 32'(flags[0]), 32'd0);
    check_eq("rst_aluop", 32'(aluop[0]), 32'(A_NOP));
    check_eq("rst_regs",  32'(regs[0]),  32'd0);
    check_eq("rst_ill",   32'(ill[0]),   32'd0);
    check_eq("rst_cnt",   32'(cnt[0]),   32'd0);
    rst_n = 1'b1;

    // Single ADD x3,x1,x2, then drain.
    inst = I_ADD3; inst_valid = 1'b1;
    #1 check_eq("add_ready", 32'(ready[0]), 32'd1);
    tick;
    inst_valid = 1'b0;
    check_eq("add_oval",  32'(oval[0]),  32'd1);
    check_eq("add_aluop", 32'(aluop[0]), 32'(A_ADD));
    check_eq("add_flags", 32'(flags[0]), 32'(F_R));
    check_eq("add_regs",  32'(regs[0]),  32'({5'd1, 5'd2, 5'd3}));
    tick;
    check_eq("drain_oval", 32'(oval[0]), 32'd0);

    // Execute stall for three cycles, then release.
    inst = I_ADD3; inst_valid = 1'b1;
    tick;
    ex_ready = 1'b0; inst = I_LUI4;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("stall_ready", 32'(ready[0]), 32'd0);
      tick;
      check_eq("stall_oval",  32'(oval[0]),  32'd1);
      check_eq("stall_regs",  32'(regs[0]),  32'({5'd1, 5'd2, 5'd3}));
      check_eq("stall_aluop", 32'(aluop[0]), 32'(A_ADD));
    end
    ex_ready = 1'b1;
    #1 check_eq("release_ready", 32'(ready[0]), 32'd1);
    tick;
    check_eq("lui_oval",  32'(oval[0]),  32'd1);
    check_eq("lui_regs",  32'(regs[0]),  32'({5'd0, 5'd0, 5'd4}));
    check_eq("lui_flags", 32'(flags[0]), 32'(F_LUI));

    // Flush with a held output and an incoming instruction.
    ex_ready = 1'b0; inst = I_ADD3; inst_valid = 1'b1; flush = 1'b1;
    #1 check_eq("flush_ready", 32'(ready[0]), 32'd0);
    tick;
    flush = 1'b0; inst_valid = 1'b0; ex_ready = 1'b1;
    check_eq("flush_oval", 32'(oval[0]), 32'd0);
    tick;
    check_eq("flush_late", 32'(oval[0]), 32'd0);
    check_eq("flush_cnt",  32'(cnt[0]),  32'd0);

    // Decode table, issued back to back.
    for (int v = 0; v < 10; v++) begin
      inst = vecs[v].ins; inst_valid = 1'b1;
      #1 check_eq($sformatf("v%0d_ready", v), 32'(ready[0]), 32'd1);
      tick;
      check_eq($sformatf("v%0d_oval", v),  32'(oval[0]),  32'd1);
      check_eq($sformatf("v%0d_flags", v), 32'(flags[0]), 32'(vecs[v].fl));
      check_eq($sformatf("v%0d_aluop", v), 32'(aluop[0]), 32'(vecs[v].alu));
      check_eq($sformatf("v%0d_ill", v),   32'(ill[0]),   32'(vecs[v].il));
      check_eq($sformatf("v%0d_regs", v),  32'(regs[0]),  32'(vecs[v].rr));
    end
    inst_valid = 1'b0;
    tick;

    // Load-use pairs: LW x5 then ADD x6,x5,x5 held for three cycles; 19 hazards total.
    for (int k = 0; k < 19; k++) begin
      inst = I_LW5; inst_valid = 1'b1;
      if (k == 0) begin
        #1 check_eq("lu_lw_ready", 32'(ready[0]), 32'd1);
      end
      tick;
      if (k == 0) begin
        check_eq("lu_lw_oval",  32'(oval[0]),  32'd1);
        check_eq("lu_lw_flags", 32'(flags[0]), 32'(F_LW));
      end
      inst = I_ADD6;
      if (k == 0) begin
        #1 check_eq("lu_haz_ready", 32'(ready[0]), 32'd0);
        check_eq("nolu_ready", 32'(ready[1]), 32'd1);
      end
      tick;
      if (k == 0) begin
        check_eq("lu_bub_oval", 32'(oval[0]), 32'd0);
        check_eq("lu_bub_cnt",  32'(cnt[0]),  32'd1);
        check_eq("nolu_oval",   32'(oval[1]), 32'd1);
        check_eq("nolu_regs",   32'(regs[1]), 32'({5'd5, 5'd5, 5'd6}));
        check_eq("nolu_cnt",    32'(cnt[1]),  32'd0);
        #1 check_eq("lu_bub_ready", 32'(ready[0]), 32'd0);
      end
      tick;
      if (k == 0) begin
        #1 check_eq("lu_run_ready", 32'(ready[0]), 32'd1);
      end
      tick;
      if (k == 0) begin
        check_eq("lu_add_oval",  32'(oval[0]),  32'd1);
        check_eq("lu_add_regs",  32'(regs[0]),  32'({5'd5, 5'd5, 5'd6}));
        check_eq("lu_add_aluop", 32'(aluop[0]), 32'(A_ADD));
      end
      if (k == 14) begin
        check_eq("cnt15_a", 32'(cnt[0]), 32'd15);
        check_eq("cnt15_c", 32'(cnt[2]), 32'd15);
      end
    end
    check_eq("cnt19_a",   32'(cnt[0]), 32'd19);
    check_eq("cnt_sat_c", 32'(cnt[2]), 32'd15);
    check_eq("cnt_nolu",  32'(cnt[1]), 32'd0);

    // Reset while sitting in BUBBLE.
    inst = I_LW5; inst_valid = 1'b1;
    tick;
    inst = I_ADD6;
    tick;
    rst_n = 1'b0;
    #1 check_eq("bub_rst_ready", 32'(ready[0]), 32'd0);
    tick;
    check_eq("bub_rst_oval",  32'(oval[0]),  32'd0);
    check_eq("bub_rst_flags", 32'(flags[0]), 32'd0);
    check_eq("bub_rst_aluop", 32'(aluop[0]), 32'(A_NOP));
    check_eq("bub_rst_regs",  32'(regs[0]),  32'd0);
    check_eq("bub_rst_cnt_a", 32'(cnt[0]),   32'd0);
    check_eq("bub_rst_cnt_c", 32'(cnt[2]),   32'd0);
    rst_n = 1'b1;
    #1 check_eq("post_rst_ready", 32'(ready[0]), 32'd1);
    tick;
    inst_valid = 1'b0;
    check_eq("post_rst_oval", 32'(oval[0]), 32'd1);
    check_eq("post_rst_regs", 32'(regs[0]), 32'({5'd5, 5'd5, 5'd6}));
    tick;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 SHALL have parameter ALUOP_W, default 8, ALU op code width; codes are the shared define-header ALU op codes, zero-extended to ALUOP_W.
REQ-002 SHALL have parameter CNT_W, default 16, bubble counter width.
REQ-003 SHALL have parameter LU_INTERLOCK, default 1, enabling the load-use bubble.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-low (reset when rst_i==0).
REQ-006 inst_valid_i  in  1  fetch presents an instruction.
REQ-007 inst_i  in  32  instruction word.
REQ-008 inst_ready_o  out  1  stage accepts inst_i this cycle.
REQ-009 ex_ready_i  in  1  execute accepts the registered output this cycle.
REQ-010 flush_i  in  1  discard held and incoming instruction (redirect).
REQ-011 out_valid_o  out  1  registered control bundle is valid.
REQ-012 branch_o, jump_o, memread_o, memwrite_o, memtoreg_o, alusrc_o, regwrite_o, reg_read1_e_o, reg_read2_e_o  out  1 each  registered control flags.
REQ-013 aluop_o  out  ALUOP_W  registered ALU op.
REQ-014 rs1_o, rs2_o, rd_o  out  5 each  registered register addresses.
REQ-015 illegal_o  out  1  registered illegal-instruction flag.
REQ-016 bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted.

Function
REQ-017 Decode SHALL cover OP-IMM, OP, LOAD, STORE, BRANCH, LUI, AUIPC, JAL and JALR.
REQ-018 OP: alusrc_o=0, both reads enabled, for all funct3 including SLL/SRL/SRA; funct7 0100000 selects SUB (funct3 000) or SRA (funct3 101); any other non-zero funct7 is illegal.
REQ-019 OP-IMM: alusrc_o=1, read1 only; SLLI needs funct7=0000000; SRLI/SRAI need funct7 0000000/0100000; else illegal.
REQ-020 LOAD: memread_o=1, memtoreg_o=1, alusrc_o=1, aluop ADD, regwrite_o=1, read1 only.
REQ-021 STORE: memwrite_o=1, alusrc_o=1, aluop ADD, regwrite_o=0, both reads enabled.
REQ-022 BRANCH: branch_o=1, aluop SUB, alusrc_o=0, both reads enabled, regwrite_o=0.
REQ-023 LUI: alusrc_o=1, aluop ADD, regwrite_o=1, no reads. AUIPC: same flags. JAL: jump_o=1, regwrite_o=1, no reads. JALR: jump_o=1, regwrite_o=1, read1 only.
REQ-024 Unknown opcode, or illegal funct3/funct7: illegal_o=1, all other flags 0, aluop NOP, out_valid_o still asserted.
REQ-025 regwrite_o SHALL be forced 0 when rd==0; a disabled read port SHALL output address 0.
REQ-026 inst_ready_o = rst_i && !flush_i && state==RUN && !hazard && (!out_valid_o || ex_ready_i), combinational.
REQ-027 Capture, 1-cycle latency: when inst_valid_i && inst_ready_o, all outputs load the decode and out_valid_o<=1 on the next edge.
REQ-028 Drain: no capture while ex_ready_i && out_valid_o SHALL clear out_valid_o; while !ex_ready_i held outputs SHALL stay stable.
REQ-029 hazard = LU_INTERLOCK && out_valid_o && memread_o && rd_o!=0 && ex_ready_i && inst_valid_i && incoming instruction reads rd_o via an enabled port.
REQ-030 FSM states RUN and BUBBLE. RUN->BUBBLE on hazard: out_valid_o<=0 and bubble_cnt_o increments. BUBBLE->RUN unconditionally after one cycle, with inst_ready_o=0 while in BUBBLE.
REQ-031 bubble_cnt_o SHALL saturate at all-ones, never wrap.
REQ-032 flush_i SHALL take priority over capture, drain and FSM: out_valid_o<=0, state<=RUN, incoming dropped, counter unchanged.

Reset
REQ-033 With rst_i==0 at an edge: out_valid_o, all flags, illegal_o, addresses and bubble_cnt_o SHALL be 0, aluop_o=NOP, state=RUN; inst_ready_o=0 while rst_i==0.
REQ-034 Reset asserted mid-stall or in BUBBLE SHALL abandon the held instruction with no partial output.

Verification
REQ-035 ADD x3,x1,x2 (0x002081B3) valid, ex_ready=1 -> next cycle out_valid=1, aluop ADD, alusrc=0, regwrite=1, rs1=1, rs2=2, rd=3.
REQ-036 LW x5,0(x1) then ADD x6,x5,x5 back-to-back, ex_ready=1 -> one cycle out_valid=0 and inst_ready=0, bubble_cnt=1, ADD issued the cycle after.
REQ-037 Same pair with LU_INTERLOCK=0 -> no bubble, bubble_cnt stays 0.
REQ-038 ex_ready=0 for 3 cycles with valid output -> outputs stable, inst_ready=0; releasing accepts the next instruction the same cycle.
REQ-039 flush_i with held valid output and incoming valid -> next cycle out_valid=0, incoming not captured; SRAI with funct7=0000001 -> illegal_o=1, regwrite=0.
REQ-040 Force 2^CNT_W+3 hazards (CNT_W=4) -> bubble_cnt_o holds 15; rst_i=0 in BUBBLE -> all outputs 0 next edge.
